twiddle_seq: RTL and testbench

TWIDDLE_SEQ -- requirements
Module: twiddle_seq

---
 rtl/fft_pkg.sv | 34 +++
 rtl/twiddle_seq_if.sv | 31 +++
 rtl/twiddle_rom.sv | 60 ++++++
 rtl/twiddle_seq.sv | 111 +++++++++++
 tb/tb_twiddle_seq.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the FFT twiddle sequencing logic.
// Holds the multiplier code constants, FFT geometry and the sequencer FSM type.
package fft_pkg;

  localparam int N_BFLY  = 8;
  localparam int N_STAGE = 4;

  localparam int BFLY_W  = $clog2(N_BFLY);
  localparam int STAGE_W = $clog2(N_STAGE);

  localparam logic [BFLY_W-1:0]  BFLY_MAX  = BFLY_W'(N_BFLY - 1);
  localparam logic [STAGE_W-1:0] STAGE_MAX = STAGE_W'(N_STAGE - 1);

  // Magnitude codes seen by the constant multiplier (1.0, cos 22.5, cos 45, cos 67.5).
  localparam logic [7:0] CODE_ONE = 8'h01;
  localparam logic [7:0] CODE_C1  = 8'hEC;
  localparam logic [7:0] CODE_C2  = 8'hB5;
  localparam logic [7:0] CODE_C3  = 8'h61;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Twiddle exponent of a radix-2 DIF butterfly: (bfly mod (8 >> stage)) << stage.
  function automatic logic [2:0] tw_exp_of(input logic [STAGE_W-1:0] stage,
                                           input logic [BFLY_W-1:0]  bfly);
    logic [2:0] mask;
    mask = 3'b111 >> stage;
    return (bfly & mask) << stage;
  endfunction

endpackage

// File: rtl/twiddle_seq_if.sv
// Twiddle beat bus between the sequencer (master) and the multiplier stage (slave).
// One beat transfers on tw_valid & tw_ready.
interface twiddle_seq_if;
  import fft_pkg::*;

  logic                tw_valid;
  logic                tw_ready;
  logic [STAGE_W-1:0]  stage;
  logic [BFLY_W-1:0]   bfly;
  logic [2:0]          tw_exp;
  logic [7:0]          re_code;
  logic [7:0]          im_code;
  logic                re_neg;
  logic                im_neg;
  logic                re_zero;
  logic                im_zero;
  logic                last;

  modport master (
    output tw_valid, stage, bfly, tw_exp,
    output re_code, im_code, re_neg, im_neg, re_zero, im_zero, last,
    input  tw_ready
  );

  modport slave (
    input  tw_valid, stage, bfly, tw_exp,
    input  re_code, im_code, re_neg, im_neg, re_zero, im_zero, last,
    output tw_ready
  );

endinterface

// File: rtl/twiddle_rom.sv
// Exponent-to-multiplier-code lookup for W16^e = cos(2*pi*e/16) - j*sin(2*pi*e/16).
// Purely combinational; a zero part is reported as code 1.0 with a clear sign.
module twiddle_rom
  import fft_pkg::*;
(
  input  logic [2:0] tw_exp,
  output logic [7:0] re_code,
  output logic [7:0] im_code,
  output logic       re_neg,
  output logic       im_neg,
  output logic       re_zero,
  output logic       im_zero
);

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    re_code = CODE_ONE;
    im_code = CODE_ONE;
    re_neg  = 1'b0;
    im_neg  = 1'b0;
    re_zero = 1'b0;
    im_zero = 1'b0;
    unique case (tw_exp)
      3'd0: begin
        im_zero = 1'b1;
      end
      3'd1: begin
        re_code = CODE_C1;
        im_code = CODE_C3; im_neg = 1'b1;
      end
      3'd2: begin
        re_code = CODE_C2;
        im_code = CODE_C2; im_neg = 1'b1;
      end
      3'd3: begin
        re_code = CODE_C3;
        im_code = CODE_C1; im_neg = 1'b1;
      end
      3'd4: begin
        re_zero = 1'b1;
        im_neg  = 1'b1;
      end
      // Second quadrant: real part mirrors the first with a negative sign.
      3'd5: begin
        re_code = CODE_C3; re_neg = 1'b1;
        im_code = CODE_C1; im_neg = 1'b1;
      end
      3'd6: begin
        re_code = CODE_C2; re_neg = 1'b1;
        im_code = CODE_C2; im_neg = 1'b1;
      end
      3'd7: begin
        re_code = CODE_C1; re_neg = 1'b1;
        im_code = CODE_C3; im_neg = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/twiddle_seq.sv
// Twiddle sequencer for a 16-point radix-2 DIF FFT: walks stage/bfly, emits one
// registered twiddle beat per handshake and pulses done after the 32nd beat.
module twiddle_seq
  import fft_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  twiddle_seq_if.master  tw
);

  state_t state_q, state_d;

  logic [STAGE_W-1:0] stage_q, stage_nxt, stage_sel;
  logic [BFLY_W-1:0]  bfly_q,  bfly_nxt,  bfly_sel;
  logic [2:0]         exp_q,   exp_sel;
  logic [7:0]         re_code_q, im_code_q, rom_re_code, rom_im_code;
  logic               re_neg_q, im_neg_q, re_zero_q, im_zero_q, last_q;
  logic               rom_re_neg, rom_im_neg, rom_re_zero, rom_im_zero;

  logic xfer, at_last, load, advance;

  assign xfer    = (state_q == RUN) && tw.tw_ready;
  assign at_last = (stage_q == STAGE_MAX) && (bfly_q == BFLY_MAX);
  assign load    = (state_q == IDLE) && start;
  assign advance = xfer && !at_last;

  // FSM state register
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (xfer && at_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // bfly wraps naturally at its width; stage steps on that wrap.
  assign bfly_nxt  = bfly_q + 1'b1;
  assign stage_nxt = (bfly_q == BFLY_MAX) ? stage_q + 1'b1 : stage_q;

  // A new sequence always begins at stage 0, bfly 0.
  assign stage_sel = load ? '0 : stage_nxt;
  assign bfly_sel  = load ? '0 : bfly_nxt;
  assign exp_sel   = tw_exp_of(stage_sel, bfly_sel);

  twiddle_rom u_rom (
    .tw_exp  (exp_sel),
    .re_code (rom_re_code),
    .im_code (rom_im_code),
    .re_neg  (rom_re_neg),
    .im_neg  (rom_im_neg),
    .re_zero (rom_re_zero),
    .im_zero (rom_im_zero)
  );

  // Beat registers: refreshed only on sequence entry or on a non-final transfer,
  // so the beat holds steady through any backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q   <= '0;
      bfly_q    <= '0;
      exp_q     <= '0;
      re_code_q <= CODE_ONE;
      im_code_q <= CODE_ONE;
      re_neg_q  <= 1'b0;
      im_neg_q  <= 1'b0;
      re_zero_q <= 1'b0;
      im_zero_q <= 1'b1;
      last_q    <= 1'b0;
    end else if (load || advance) begin
      stage_q   <= stage_sel;
      bfly_q    <= bfly_sel;
      exp_q     <= exp_sel;
      re_code_q <= rom_re_code;
      im_code_q <= rom_im_code;
      re_neg_q  <= rom_re_neg;
      im_neg_q  <= rom_im_neg;
      re_zero_q <= rom_re_zero;
      im_zero_q <= rom_im_zero;
      last_q    <= (stage_sel == STAGE_MAX) && (bfly_sel == BFLY_MAX);
    end else if (xfer) begin
      last_q    <= 1'b0;
    end
  end

  // Control outputs decode the state register only; no input reaches them combinationally.
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign tw.tw_valid = (state_q == RUN);
  assign tw.stage    = stage_q;
  assign tw.bfly     = bfly_q;
  assign tw.tw_exp   = exp_q;
  assign tw.re_code  = re_code_q;
  assign tw.im_code  = im_code_q;
  assign tw.re_neg   = re_neg_q;
  assign tw.im_neg   = im_neg_q;
  assign tw.re_zero  = re_zero_q;
  assign tw.im_zero  = im_zero_q;
  assign tw.last     = last_q;

endmodule

// File: tb/tb_twiddle_seq.sv
// Directed bench for twiddle_seq: full sequences, backpressure, mid-run reset
// and ignored starts, each beat compared with a hand-written twiddle table.
module tb_twiddle_seq;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;

  twiddle_seq_if tw_bus ();

  twiddle_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .tw    (tw_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-written table indexed by exponent: re_code, re_neg, re_zero, im_code, im_neg, im_zero.
  logic [7:0] t_re_code [8] = '{8'h01, 8'hEC, 8'hB5, 8'h61, 8'h01, 8'h61, 8'hB5, 8'hEC};
  logic       t_re_neg  [8] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
  logic       t_re_zero [8] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0};
  logic [7:0] t_im_code [8] = '{8'h01, 8'h61, 8'hB5, 8'hEC, 8'h01, 8'hEC, 8'hB5, 8'h61};
  logic       t_im_neg  [8] = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1};
  logic       t_im_zero [8] = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; the bench both drives and samples 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".valid"},   32'(tw_bus.tw_valid), 32'd0);
    check({tag, ".busy"},    32'(busy),            32'd0);
    check({tag, ".done"},    32'(done),            32'd0);
    check({tag, ".last"},    32'(tw_bus.last),     32'd0);
    check({tag, ".stage"},   32'(tw_bus.stage),    32'd0);
    check({tag, ".bfly"},    32'(tw_bus.bfly),     32'd0);
    check({tag, ".exp"},     32'(tw_bus.tw_exp),   32'd0);
    check({tag, ".re_code"}, 32'(tw_bus.re_code),  32'h01);
    check({tag, ".im_code"}, 32'(tw_bus.im_code),  32'h01);
    check({tag, ".re_neg"},  32'(tw_bus.re_neg),   32'd0);
    check({tag, ".im_neg"},  32'(tw_bus.im_neg),   32'd0);
    check({tag, ".re_zero"}, 32'(tw_bus.re_zero),  32'd0);
    check({tag, ".im_zero"}, 32'(tw_bus.im_zero),  32'd1);
  endtask

  task automatic check_beat(input int idx);
    int    s, b, e;
    string t;
    s = idx / 8;
    b = idx % 8;
    e = ((b % (8 >> s)) << s) & 7;
    t = $sformatf("beat%0d", idx);
    check({t, ".valid"},   32'(tw_bus.tw_valid), 32'd1);
    check({t, ".busy"},    32'(busy),            32'd1);
    check({t, ".done"},    32'(done),            32'd0);
    check({t, ".stage"},   32'(tw_bus.stage),    32'(s));
    check({t, ".bfly"},    32'(tw_bus.bfly),     32'(b));
    check({t, ".exp"},     32'(tw_bus.tw_exp),   32'(e));
    check({t, ".re_code"}, 32'(tw_bus.re_code),  32'(t_re_code[e]));
    check({t, ".re_neg"},  32'(tw_bus.re_neg),   32'(t_re_neg[e]));
    check({t, ".re_zero"}, 32'(tw_bus.re_zero),  32'(t_re_zero[e]));
    check({t, ".im_code"}, 32'(tw_bus.im_code),  32'(t_im_code[e]));
    check({t, ".im_neg"},  32'(tw_bus.im_neg),   32'(t_im_neg[e]));
    check({t, ".im_zero"}, 32'(tw_bus.im_zero),  32'(t_im_zero[e]));
    check({t, ".last"},    32'(tw_bus.last),     32'(idx == 31));
  endtask

  // One sequence: optional 'stall_len' cycles of backpressure at beat 'stall_at',
  // optional reset at beat 'rst_at', optional start held high throughout.
  task automatic run_seq(input int stall_at, input int stall_len, input int rst_at,
                         input bit start_busy);
    int idx, stalled, cyc;
    idx = 0; stalled = 0; cyc = 0;
    start = 1'b1;
    tick();
    start = start_busy;
    while (idx < 32 && cyc < 200) begin
      cyc++;
      check_beat(idx);
      if (idx == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check_reset("rst_mid");
        tick();
        check("rst_mid.no_done", 32'(done), 32'd0);
        check("rst_mid.idle",    32'(tw_bus.tw_valid), 32'd0);
        return;
      end
      if (idx == stall_at && stalled < stall_len) begin
        tw_bus.tw_ready = 1'b0;
        stalled++;
      end else begin
        tw_bus.tw_ready = 1'b1;
        idx++;
      end
      tick();
    end
    check("seq.beat_count", 32'(idx), 32'd32);
    check("done.pulse", 32'(done),            32'd1);
    check("done.busy",  32'(busy),            32'd0);
    check("done.valid", 32'(tw_bus.tw_valid), 32'd0);
    start = start_busy;
    tick();
    start = 1'b0;
    check("post.done",  32'(done),            32'd0);
    check("post.busy",  32'(busy),            32'd0);
    check("post.valid", 32'(tw_bus.tw_valid), 32'd0);
    tick();
    check("post2.busy",  32'(busy),            32'd0);
    check("post2.valid", 32'(tw_bus.tw_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    tw_bus.tw_ready = 1'b0;
    tick();
    tick();
    check_reset("reset");

    // Reset outranks a simultaneous start.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_reset("rst_vs_start");
    rst = 1'b0;

    // tw_ready toggling while idle has no effect.
    tw_bus.tw_ready = 1'b1;
    tick();
    check_reset("idle_ready");

    run_seq(-1, 0, -1, 1'b0);   // plain sequence
    run_seq(10, 3, -1, 1'b1);   // backpressure at beat 10, start held while busy and in DONE
    run_seq(-1, 0, 17, 1'b0);   // reset interrupts at beat 17
    run_seq(-1, 0, -1, 1'b0);   // replays from stage 0, bfly 0

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
